// File: rtl/tcm_sram_port_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tcm_pkg
// Shared types and helpers for the TCM SRAM port controller.
//   resp_entry_t   : one buffered response {data, tag, error}
//   TCM_FIFO_DEPTH : response buffer depth (two entries matches the credit
//                    limit of one in-flight access plus one buffered word)
//   tcm_in_window  : tests whether a base-relative byte offset falls inside
//                    a 2^(aw+3)-byte SRAM window
// ---------------------------------------------------------------------------
package tcm_pkg;

  localparam int unsigned TCM_FIFO_DEPTH = 2;

  // Tag field is sized for the widest tag any instance may use; narrower
  // instances zero-extend on push and slice on pop.
  localparam int unsigned TCM_TAG_W_MAX  = 16;

  typedef struct packed {
    logic [31:0]              data;
    logic [TCM_TAG_W_MAX-1:0] tag;
    logic                     error;
  } resp_entry_t;

  // Unsigned window test: offset < 2^(aw+3). Written as a shift so that
  // every offset bit takes part and no 33-bit compare is needed.
  function automatic logic tcm_in_window(input logic [31:0] offset,
                                         input int unsigned aw);
    return ((offset >> (aw + 32'd3)) == 32'd0);
  endfunction

endpackage

// File: rtl/tcm_sram_port_ctrl_resp_fifo.sv
// ---------------------------------------------------------------------------
// tcm_resp_fifo
// Two-entry, in-order response buffer. Head entry is driven straight from
// storage flops so the response outputs are registered.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   push_i         : write push_entry_i at the tail
//   push_entry_i   : entry to store
//   pop_i          : drop the head entry (ignored when empty)
//   head_o         : oldest stored entry
//   count_o        : number of stored entries (0..2)
// Push and pop in the same cycle are legal at any occupancy.
//
// tcm_resp_fifo_chk
// Companion checker: flags a push while the buffer is already full.
// ---------------------------------------------------------------------------
module tcm_resp_fifo
  import tcm_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  resp_entry_t push_entry_i,
  input  logic        pop_i,
  output resp_entry_t head_o,
  output logic [1:0]  count_o
);

  resp_entry_t mem_q [TCM_FIFO_DEPTH];
  resp_entry_t mem_d [TCM_FIFO_DEPTH];
  // One-bit pointers wrap naturally for a depth of two.
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q,  count_d;
  logic        pop_ok_s;
  logic        push_ok_s;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    pop_ok_s  = pop_i && (count_q != 2'd0);
    // A full buffer can still take a push when the head leaves this cycle.
    push_ok_s = push_i && ((count_q != 2'd2) || pop_ok_s);

    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_entry_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end

    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Buffer state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < TCM_FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

module tcm_resp_fifo_chk (
  input logic       clk_i,
  input logic       rst_ni,
  input logic       push_i,
  input logic [1:0] count_i
);

  // The credit limit guarantees a slot for every push.
  a_no_push_when_full : assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(push_i && (count_i == 2'd2))
  );

endmodule

// File: rtl/tcm_sram_port_ctrl.sv
// ---------------------------------------------------------------------------
// tcm_sram_port_ctrl
// Upstream controller for one RW port of the 32x64 dual-port TCM SRAM macro.
// Front side (core):
//   req_valid_i/req_accept_o  request handshake
//   req_rd_i, req_wr_i[3:0]   read / byte-enable write (write wins)
//   req_addr_i, req_data_i    byte address, 32-bit write data
//   req_tag_i                 tag echoed on the response
//   resp_valid_o/resp_ready_i response handshake
//   resp_data_o, resp_tag_o, resp_error_o
// Back side (macro, same clock):
//   sram_csb_o, sram_web_o    active-low select / write enable
//   sram_wmask_o[7:0]         byte mask over the 64-bit word
//   sram_addr_o, sram_din_o   word address, duplicated write data
//   sram_dout_i               read data, valid only at the posedge ending
//                             the cycle after the macro registered the read
// Request to response latency is two cycles; at most two requests are
// outstanding (one at the macro, one buffered), so the buffer never
// overflows.
// ---------------------------------------------------------------------------
module tcm_sram_port_ctrl
  import tcm_pkg::*;
#(
  parameter int unsigned SRAM_AW   = 5,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned TAG_W     = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  input  logic               req_rd_i,
  input  logic [3:0]         req_wr_i,
  input  logic [31:0]        req_addr_i,
  input  logic [31:0]        req_data_i,
  input  logic [TAG_W-1:0]   req_tag_i,
  output logic               req_accept_o,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic [31:0]        resp_data_o,
  output logic [TAG_W-1:0]   resp_tag_o,
  output logic               resp_error_o,
  output logic               sram_csb_o,
  output logic               sram_web_o,
  output logic [7:0]         sram_wmask_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [63:0]        sram_din_o,
  input  logic [63:0]        sram_dout_i
);

  logic [31:0]        offset_s;
  logic               in_range_s;
  logic               is_wr_s;
  logic [2:0]         credit_s;
  logic               accept_s;
  logic               fire_s;
  logic [1:0]         fifo_count_s;
  resp_entry_t        push_entry_s;
  resp_entry_t        head_s;

  // Capture of the access currently at the macro.
  logic               inflight_q, inflight_d;
  logic [TAG_W-1:0]   cap_tag_q,  cap_tag_d;
  logic               cap_hi_q,   cap_hi_d;
  logic               cap_rd_q,   cap_rd_d;
  logic               cap_err_q,  cap_err_d;

  // Address and data pins keep their last driven value when idle.
  logic [SRAM_AW-1:0] addr_hold_q, addr_hold_d;
  logic [63:0]        din_hold_q,  din_hold_d;

  logic               unused_s;

  assign offset_s   = req_addr_i - BASE_ADDR;
  assign in_range_s = tcm_in_window(offset_s, SRAM_AW);
  assign is_wr_s    = (req_wr_i != 4'd0);

  // Credit counts every accepted access that has not yet left the buffer.
  assign credit_s   = {1'b0, fifo_count_s} + {2'b00, inflight_q};
  // Registers only, plus the reset gate so nothing is accepted in reset.
  assign accept_s   = rst_ni && (credit_s < 3'd2);
  assign fire_s     = req_valid_i && accept_s && (req_rd_i || is_wr_s);

  // Macro pin drive in the fire cycle; the macro registers them at the
  // following posedge.
  always_comb begin
    sram_csb_o   = 1'b1;
    sram_web_o   = 1'b1;
    sram_wmask_o = 8'h00;
    sram_addr_o  = addr_hold_q;
    sram_din_o   = din_hold_q;
    if (fire_s) begin
      sram_csb_o  = ~in_range_s;
      sram_web_o  = ~is_wr_s;
      sram_addr_o = offset_s[SRAM_AW+2:3];
      sram_din_o  = {req_data_i, req_data_i};
      if (is_wr_s) begin
        sram_wmask_o = offset_s[2] ? {req_wr_i, 4'b0000} : {4'b0000, req_wr_i};
      end else begin
        sram_wmask_o = 8'h00;
      end
    end else begin
      sram_csb_o   = 1'b1;
      sram_web_o   = 1'b1;
      sram_wmask_o = 8'h00;
    end
  end

  // Next-state for the in-flight capture and the held pin values.
  always_comb begin
    inflight_d  = fire_s;
    cap_tag_d   = cap_tag_q;
    cap_hi_d    = cap_hi_q;
    cap_rd_d    = cap_rd_q;
    cap_err_d   = cap_err_q;
    addr_hold_d = addr_hold_q;
    din_hold_d  = din_hold_q;
    if (fire_s) begin
      cap_tag_d   = req_tag_i;
      cap_hi_d    = offset_s[2];
      cap_rd_d    = ~is_wr_s;
      cap_err_d   = ~in_range_s;
      addr_hold_d = offset_s[SRAM_AW+2:3];
      din_hold_d  = {req_data_i, req_data_i};
    end else begin
      cap_tag_d   = cap_tag_q;
      cap_hi_d    = cap_hi_q;
      cap_rd_d    = cap_rd_q;
      cap_err_d   = cap_err_q;
      addr_hold_d = addr_hold_q;
      din_hold_d  = din_hold_q;
    end
  end

  // In-flight capture and held pin registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q  <= 1'b0;
      cap_tag_q   <= '0;
      cap_hi_q    <= 1'b0;
      cap_rd_q    <= 1'b0;
      cap_err_q   <= 1'b0;
      addr_hold_q <= '0;
      din_hold_q  <= 64'd0;
    end else begin
      inflight_q  <= inflight_d;
      cap_tag_q   <= cap_tag_d;
      cap_hi_q    <= cap_hi_d;
      cap_rd_q    <= cap_rd_d;
      cap_err_q   <= cap_err_d;
      addr_hold_q <= addr_hold_d;
      din_hold_q  <= din_hold_d;
    end
  end

  // Response entry built from macro dout. It is pushed at the posedge that
  // ends the cycle after the fire, the only edge where dout is defined.
  always_comb begin
    push_entry_s       = '0;
    push_entry_s.tag   = TCM_TAG_W_MAX'(cap_tag_q);
    push_entry_s.error = cap_err_q;
    if (cap_rd_q && !cap_err_q) begin
      push_entry_s.data = cap_hi_q ? sram_dout_i[63:32] : sram_dout_i[31:0];
    end else begin
      push_entry_s.data = 32'd0;
    end
  end

  tcm_resp_fifo u_resp_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (inflight_q),
    .push_entry_i (push_entry_s),
    .pop_i        (resp_ready_i),
    .head_o       (head_s),
    .count_o      (fifo_count_s)
  );

  tcm_resp_fifo_chk u_resp_fifo_chk (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (inflight_q),
    .count_i (fifo_count_s)
  );

  assign req_accept_o = accept_s;
  assign resp_valid_o = (fifo_count_s != 2'd0);
  assign resp_data_o  = head_s.data;
  assign resp_tag_o   = head_s.tag[TAG_W-1:0];
  assign resp_error_o = head_s.error;

  // Byte-lane address bits and spare tag bits carry no information here.
  assign unused_s = ^{offset_s[1:0], head_s.tag};

endmodule
